// File: rtl/rx_frame_filter_pkg.sv
// Shared types and entry layout for the receive frame filter.
package rx_frame_filter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DROP  = 2'd2
  } rx_wr_state_t;

  localparam int DATA_WIDTH  = 32;
  localparam int DATA_NBYTES = DATA_WIDTH / 8;
  localparam int LAST_BIT    = 36;
  localparam int KEEP_LSB    = 32;
  localparam int ENTRY_WIDTH = LAST_BIT + 1;

  // Buffer entry layout: {last, keep, data}.
  function automatic logic [ENTRY_WIDTH-1:0] pack_entry(
    input logic                   last,
    input logic [DATA_NBYTES-1:0] keep,
    input logic [DATA_WIDTH-1:0]  data
  );
    return {last, keep, data};
  endfunction

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rx_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module rx_frame_ram
  import rx_frame_filter_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                   i_clk,
  input  logic                   wr_en_i,
  input  logic [ADDR_WIDTH-1:0]  wr_addr_i,
  input  logic [ENTRY_WIDTH-1:0] wr_data_i,
  input  logic                   rd_en_i,
  input  logic [ADDR_WIDTH-1:0]  rd_addr_i,
  output logic [ENTRY_WIDTH-1:0] rd_data_o
);

  logic [ENTRY_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];

  // Storage write and one-cycle registered read; no reset so it maps to block RAM.
  always_ff @(posedge i_clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/rx_frame_filter.sv
// Store-and-forward receive filter: speculative frame writes, commit on good CRC,
// replay of committed frames through a 2-entry output skid stage.
module rx_frame_filter
  import rx_frame_filter_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [DATA_WIDTH-1:0]  s00_axis_tdata,
  input  logic [DATA_NBYTES-1:0] s00_axis_tkeep,
  input  logic                   s00_axis_tvalid,
  input  logic                   s00_axis_tlast,
  input  logic                   s00_axis_tuser,
  output logic [DATA_WIDTH-1:0]  m00_axis_tdata,
  output logic [DATA_NBYTES-1:0] m00_axis_tkeep,
  output logic                   m00_axis_tvalid,
  output logic                   m00_axis_tlast,
  input  logic                   m00_axis_tready,
  output logic                   o_drop_crc,
  output logic                   o_drop_overflow,
  output logic [15:0]            o_frames_ok,
  output logic [15:0]            o_frames_dropped
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PTR_W-1:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  rx_wr_state_t           state_q;
  logic [PTR_W-1:0]       wr_ptr_q, commit_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0]  shadow_data_q;
  logic [DATA_NBYTES-1:0] shadow_keep_q;
  logic                   drop_crc_q, drop_ovf_q;
  logic [15:0]            frames_ok_q, frames_dropped_q;

  logic                   has_keep_s, full_s, written_s, overflow_s, wr_en_s;
  logic [PTR_W-1:0]       wr_ptr_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_s;
  logic [ENTRY_WIDTH-1:0] wr_data_s, rd_data_s;

  logic                   rd_en_s, pop_s, pending_q;
  logic [1:0]             cnt_q, occ_s;
  logic [ENTRY_WIDTH-1:0] slot0_q, slot1_q;

  // Write-side decode: buffer write (normal beat or zero-keep tail fix-up) and post-beat pointer.
  always_comb begin
    has_keep_s = (s00_axis_tkeep != 4'b0000);
    full_s     = ((wr_ptr_q - rd_ptr_q) == DEPTH);
    written_s  = (wr_ptr_q != commit_ptr_q);
    overflow_s = s00_axis_tvalid && (state_q != DROP) && has_keep_s && full_s;
    wr_en_s    = 1'b0;
    wr_addr_s  = wr_ptr_q[ADDR_WIDTH-1:0];
    wr_data_s  = pack_entry(s00_axis_tlast, s00_axis_tkeep, s00_axis_tdata);
    wr_ptr_d   = wr_ptr_q;
    if (s00_axis_tvalid && (state_q != DROP) && !overflow_s) begin
      if (has_keep_s) begin
        wr_en_s  = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else if (s00_axis_tlast && written_s) begin
        // Terminating beat carries no bytes: re-mark the previous word as last.
        wr_en_s   = 1'b1;
        wr_addr_s = wr_ptr_q[ADDR_WIDTH-1:0] - ADDR_ONE;
        wr_data_s = pack_entry(1'b1, shadow_keep_q, shadow_data_q);
      end else begin
        wr_en_s = 1'b0;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Write FSM: pointers, commit/discard decisions, drop pulses and statistics.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q          <= IDLE;
      wr_ptr_q         <= '0;
      commit_ptr_q     <= '0;
      shadow_data_q    <= '0;
      shadow_keep_q    <= '0;
      drop_crc_q       <= 1'b0;
      drop_ovf_q       <= 1'b0;
      frames_ok_q      <= 16'd0;
      frames_dropped_q <= 16'd0;
    end else begin
      drop_crc_q <= 1'b0;
      drop_ovf_q <= 1'b0;
      case (state_q)
        IDLE, FRAME: begin
          if (s00_axis_tvalid) begin
            if (overflow_s) begin
              wr_ptr_q <= commit_ptr_q;
              if (s00_axis_tlast) begin
                drop_ovf_q       <= 1'b1;
                frames_dropped_q <= sat_inc16(frames_dropped_q);
                state_q          <= IDLE;
              end else begin
                state_q <= DROP;
              end
            end else begin
              wr_ptr_q <= wr_ptr_d;
              if (has_keep_s) begin
                shadow_data_q <= s00_axis_tdata;
                shadow_keep_q <= s00_axis_tkeep;
              end
              if (s00_axis_tlast) begin
                state_q <= IDLE;
                if (s00_axis_tuser) begin
                  // A frame with no stored words is discarded without any report.
                  if (wr_ptr_d != commit_ptr_q) begin
                    commit_ptr_q <= wr_ptr_d;
                    frames_ok_q  <= sat_inc16(frames_ok_q);
                  end
                end else begin
                  wr_ptr_q         <= commit_ptr_q;
                  drop_crc_q       <= 1'b1;
                  frames_dropped_q <= sat_inc16(frames_dropped_q);
                end
              end else begin
                state_q <= FRAME;
              end
            end
          end
        end
        DROP: begin
          if (s00_axis_tvalid && s00_axis_tlast) begin
            drop_ovf_q       <= 1'b1;
            frames_dropped_q <= sat_inc16(frames_dropped_q);
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  rx_frame_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .i_clk     (i_clk),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wr_addr_s),
    .wr_data_i (wr_data_s),
    .rd_en_i   (rd_en_s),
    .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data_o (rd_data_s)
  );

  // Read issue: only committed words, and only if the skid stage can absorb the in-flight read.
  always_comb begin
    pop_s   = (cnt_q != 2'd0) && m00_axis_tready;
    occ_s   = cnt_q + {1'b0, pending_q} - {1'b0, pop_s};
    rd_en_s = (rd_ptr_q != commit_ptr_q) && (occ_s < 2'd2);
  end

  // Read pointer, RAM-latency tracking and the 2-entry output skid stage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_ptr_q  <= '0;
      pending_q <= 1'b0;
      cnt_q     <= 2'd0;
      slot0_q   <= '0;
      slot1_q   <= '0;
    end else begin
      if (rd_en_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      pending_q <= rd_en_s;
      case ({pending_q, pop_s})
        2'b01: begin
          slot0_q <= slot1_q;
          cnt_q   <= cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) begin
            slot0_q <= rd_data_s;
          end else begin
            slot1_q <= rd_data_s;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            slot0_q <= rd_data_s;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= rd_data_s;
          end
        end
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign m00_axis_tvalid  = (cnt_q != 2'd0);
  assign m00_axis_tdata   = slot0_q[DATA_WIDTH-1:0];
  assign m00_axis_tkeep   = slot0_q[LAST_BIT-1:KEEP_LSB];
  assign m00_axis_tlast   = slot0_q[LAST_BIT];
  assign o_drop_crc       = drop_crc_q;
  assign o_drop_overflow  = drop_ovf_q;
  assign o_frames_ok      = frames_ok_q;
  assign o_frames_dropped = frames_dropped_q;

endmodule

// File: tb/tb_rx_frame_filter.sv
// Directed bench for rx_frame_filter with an expected-beat scoreboard.
module tb_rx_frame_filter;

  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_tdata = 32'd0;
  logic [3:0]  s_tkeep = 4'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b1;
  logic        drop_crc, drop_ovf;
  logic [15:0] frames_ok, frames_dropped;

  int errors = 0;
  int checks = 0;
  int crc_pulses = 0;
  int ovf_pulses = 0;
  logic rand_en = 1'b0;
  logic tready_fixed = 1'b1;
  logic [36:0] exp_q [$];

  rx_frame_filter #(.ADDR_WIDTH(AW)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tkeep   (s_tkeep),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tlast   (s_tlast),
    .s00_axis_tuser   (s_tuser),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tkeep   (m_tkeep),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tlast   (m_tlast),
    .m00_axis_tready  (m_tready),
    .o_drop_crc       (drop_crc),
    .o_drop_overflow  (drop_ovf),
    .o_frames_ok      (frames_ok),
    .o_frames_dropped (frames_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream ready: fixed level or pseudo-random, changed just after each edge.
  always @(posedge clk) begin
    #1;
    m_tready = rand_en ? 1'($urandom_range(0, 1)) : tready_fixed;
  end

  // Output monitor: any valid beat must equal the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (drop_crc) crc_pulses++;
      if (drop_ovf) ovf_pulses++;
      if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(m_tvalid), 64'd0);
        end else begin
          check("out_beat", 64'({m_tlast, m_tkeep, m_tdata}), 64'(exp_q[0]));
          if (m_tready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; s_tkeep = 4'd0;
  endtask

  // n data beats; with zk_end the frame ends with an extra zero-keep tlast beat.
  task automatic send_frame(input int n, input logic [31:0] base, input logic [3:0] last_keep,
                            input logic u, input bit expect_out, input bit zk_end);
    logic       lst;
    logic [3:0] k;
    for (int i = 0; i < n; i++) begin
      lst = (i == n - 1) && !zk_end;
      k   = lst ? last_keep : 4'hF;
      if (expect_out) exp_q.push_back({(i == n - 1), k, base + 32'(i)});
      send_beat(base + 32'(i), k, lst, u);
    end
    if (zk_end) send_beat(32'hDEAD_BEEF, 4'h0, 1'b1, u);
  endtask

  task automatic wait_drain(input string tag);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || m_tvalid) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    check("rst_tkeep", 64'(m_tkeep), 64'd0);
    check("rst_pulses", 64'({drop_crc, drop_ovf}), 64'd0);
    check("rst_ok", 64'(frames_ok), 64'd0);
    check("rst_dropped", 64'(frames_dropped), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Good 16-beat frame filling the buffer exactly; commit latency
    send_frame(16, 32'hA000_0000, 4'b0011, 1'b1, 1'b1, 1'b0);
    @(negedge clk); check("lat_e0", 64'(m_tvalid), 64'd0);
    @(negedge clk); check("lat_e1", 64'(m_tvalid), 64'd0);
    @(negedge clk); check("lat_e2", 64'(m_tvalid), 64'd1);
    @(posedge clk); #1;
    wait_drain("good16");
    check("good16_ok", 64'(frames_ok), 64'd1);

    // Bad CRC frame, then a good 4-beat frame
    send_frame(10, 32'hB000_0000, 4'hF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("crc_pulse_hi", 64'(drop_crc), 64'd1);
    check("crc_dropped", 64'(frames_dropped), 64'd1);
    @(negedge clk); check("crc_pulse_lo", 64'(drop_crc), 64'd0);
    @(posedge clk); #1;
    send_frame(4, 32'hC000_0000, 4'b0111, 1'b1, 1'b1, 1'b0);
    wait_drain("after_crc");
    check("crc_pulses", 64'(crc_pulses), 64'd1);
    check("crc_ok", 64'(frames_ok), 64'd2);

    // Zero-keep terminating beat
    send_frame(5, 32'hD000_0000, 4'hF, 1'b1, 1'b1, 1'b1);
    wait_drain("zerokeep");
    check("zk_ok", 64'(frames_ok), 64'd3);
    check("zk_dropped", 64'(frames_dropped), 64'd1);

    // Overflow with output stalled
    tready_fixed = 1'b0;
    repeat (2) @(posedge clk); #1;
    send_frame(12, 32'hE000_0000, 4'hF, 1'b1, 1'b1, 1'b0);
    send_frame(8, 32'hF000_0000, 4'hF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("ovf_pulse_hi", 64'(drop_ovf), 64'd1);
    check("ovf_dropped", 64'(frames_dropped), 64'd2);
    @(negedge clk); check("ovf_pulse_lo", 64'(drop_ovf), 64'd0);
    check("ovf_stalled_valid", 64'(m_tvalid), 64'd1);
    repeat (5) @(posedge clk); #1;
    tready_fixed = 1'b1;
    wait_drain("overflow");
    check("ovf_pulses", 64'(ovf_pulses), 64'd1);
    check("ovf_ok", 64'(frames_ok), 64'd4);

    // Random backpressure over three back-to-back frames
    rand_en = 1'b1;
    send_frame(5, 32'h1100_0000, 4'b0001, 1'b1, 1'b1, 1'b0);
    send_frame(7, 32'h2200_0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    send_frame(3, 32'h3300_0000, 4'b0011, 1'b1, 1'b1, 1'b0);
    wait_drain("backpressure");
    rand_en = 1'b0;
    @(posedge clk); #1;
    check("bp_ok", 64'(frames_ok), 64'd7);
    check("bp_dropped", 64'(frames_dropped), 64'd2);

    // Reset in the middle of a frame, then a good 2-beat frame
    send_beat(32'h4400_0000, 4'hF, 1'b0, 1'b0);
    send_beat(32'h4400_0001, 4'hF, 1'b0, 1'b0);
    send_beat(32'h4400_0002, 4'hF, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
    check("mid_rst_ok", 64'(frames_ok), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(2, 32'h5500_0000, 4'b0011, 1'b1, 1'b1, 1'b0);
    wait_drain("after_reset");
    repeat (4) @(posedge clk); #1;
    check("final_ok", 64'(frames_ok), 64'd1);
    check("final_dropped", 64'(frames_dropped), 64'd0);
    check("final_idle", 64'(m_tvalid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
